alu_seq: RTL and testbench

//  Registered, parametrised successor of the 8-bit datapath ALU. Accepts one operation
//  per valid/ready handshake and returns a registered result with status flags.

---
 rtl/alu_seq_if.sv | 27 ++
 rtl/alu_seq.sv | 145 ++++++++++++++
 tb/tb_alu_seq.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Request/result handshake bundle for the sequential ALU.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       ALU_Sel;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ALU_Out;
  logic             zero;
  logic             negative;
  logic             carry;
  logic             overflow;

  modport master (
    output in_valid, ALU_Sel, A, B, out_ready,
    input  in_ready, out_valid, ALU_Out, zero, negative, carry, overflow
  );

  modport slave (
    input  in_valid, ALU_Sel, A, B, out_ready,
    output in_ready, out_valid, ALU_Out, zero, negative, carry, overflow
  );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU: one op per valid/ready handshake, single-cycle logic/arith ops,
// iterative shift-add multiply taking WIDTH cycles. Result and flags held until taken.
module alu_seq #(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, MUL} state_t;

  state_t             state;
  logic [WIDTH-1:0]   alu_out;
  logic               out_valid;
  logic               zero_q;
  logic               neg_q;
  logic               carry_q;
  logic               ovf_q;

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  logic               in_ready;
  logic               accept;
  logic               is_mul;
  logic [WIDTH-1:0]   res;
  logic               res_c;
  logic               res_v;
  logic [WIDTH:0]     wide;

  assign in_ready = (state == IDLE) && (!out_valid || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign is_mul   = MUL_EN && (bus.ALU_Sel == 4'b1011);

  // Single-cycle result and flags for the incoming operands.
  always_comb begin
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    wide  = '0;
    case (bus.ALU_Sel)
      4'b0001: res = ~bus.A;
      4'b0011: begin
        wide  = {1'b0, bus.A} + {1'b0, bus.B};
        res   = wide[WIDTH-1:0];
        res_c = wide[WIDTH];
        res_v = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (res[WIDTH-1] != bus.A[WIDTH-1]);
      end
      4'b0100: begin
        wide  = {1'b0, bus.A} - {1'b0, bus.B};
        res   = wide[WIDTH-1:0];
        res_c = wide[WIDTH];
        res_v = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (res[WIDTH-1] != bus.A[WIDTH-1]);
      end
      4'b0101: res = bus.A & bus.B;
      4'b0110: res = bus.A | bus.B;
      4'b1010: res = '0;
      4'b1100: begin
        res   = {bus.A[WIDTH-2:0], 1'b0};
        res_c = bus.A[WIDTH-1];
      end
      4'b1101: begin
        res   = {1'b0, bus.A[WIDTH-1:1]};
        res_c = bus.A[0];
      end
      default: res = bus.A;
    endcase
  end

  // One partial-product step of the shift-add multiplier.
  always_comb begin
    acc_next = mplier[0] ? (acc + mcand) : acc;
  end

  // Control FSM with registered result, flags and out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      alu_out   <= '0;
      zero_q    <= 1'b0;
      neg_q     <= 1'b0;
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
      mcand     <= '0;
      acc       <= '0;
      mplier    <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_mul) begin
              state     <= MUL;
              out_valid <= 1'b0;
              mcand     <= {{WIDTH{1'b0}}, bus.A};
              mplier    <= bus.B;
              acc       <= '0;
              cnt       <= '0;
            end else begin
              out_valid <= 1'b1;
              alu_out   <= res;
              zero_q    <= (res == '0);
              neg_q     <= res[WIDTH-1];
              carry_q   <= res_c;
              ovf_q     <= res_v;
            end
          end else if (bus.out_ready) begin
            out_valid <= 1'b0;
          end
        end
        MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state     <= IDLE;
            out_valid <= 1'b1;
            alu_out   <= acc_next[WIDTH-1:0];
            zero_q    <= (acc_next[WIDTH-1:0] == '0);
            neg_q     <= acc_next[WIDTH-1];
            carry_q   <= |acc_next[2*WIDTH-1:WIDTH];
            ovf_q     <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.ALU_Out   = alu_out;
  assign bus.zero      = zero_q;
  assign bus.negative  = neg_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: flags, latency, back-pressure, streaming, reset abort,
// and a MUL_EN=0 build.
module tb_alu_seq;
  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  alu_seq_if #(.WIDTH(8)) bus ();
  alu_seq_if #(.WIDTH(8)) bus0 ();

  alu_seq #(.WIDTH(8), .MUL_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  alu_seq #(.WIDTH(8), .MUL_EN(1'b0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic [7:0] o, input logic z, input logic n,
                         input logic c, input logic v);
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, ".ALU_Out"},   32'(bus.ALU_Out),   32'(o));
    chk({tag, ".zero"},      32'(bus.zero),      32'(z));
    chk({tag, ".negative"},  32'(bus.negative),  32'(n));
    chk({tag, ".carry"},     32'(bus.carry),     32'(c));
    chk({tag, ".overflow"},  32'(bus.overflow),  32'(v));
  endtask

  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.ALU_Sel  = op;
    bus.A        = a;
    bus.B        = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic mul_wait(input string tag);
    int edges;
    edges = 1;
    while (!bus.out_valid && edges < 20) begin
      chk({tag, ".in_ready_busy"}, 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
      edges++;
    end
    chk({tag, ".latency"}, 32'(edges), 32'd9);
  endtask

  initial begin
    int spurious;
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.ALU_Sel   = 4'b0000;
    bus.A         = '0;
    bus.B         = '0;
    bus.out_ready = 1'b1;
    bus0.in_valid  = 1'b0;
    bus0.ALU_Sel   = 4'b0000;
    bus0.A         = '0;
    bus0.B         = '0;
    bus0.out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst.ALU_Out",   32'(bus.ALU_Out),   32'd0);
    chk("rst.flags",     32'({bus.zero, bus.negative, bus.carry, bus.overflow}), 32'd0);
    chk("rst.in_ready",  32'(bus.in_ready),  32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Single-cycle ops, latency 1
    chk("add.pre_valid", 32'(bus.out_valid), 32'd0);
    issue(4'b0011, 8'hF0, 8'h20);
    chk_res("add_f0_20", 8'h10, 1'b0, 1'b0, 1'b1, 1'b0);
    issue(4'b0100, 8'h05, 8'h07);
    chk_res("sub_05_07", 8'hFE, 1'b0, 1'b1, 1'b1, 1'b0);
    issue(4'b0011, 8'h7F, 8'h01);
    chk_res("add_7f_01", 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);
    issue(4'b1010, 8'h33, 8'h44);
    chk_res("clear",     8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    issue(4'b1100, 8'h81, 8'h00);
    chk_res("shl_81",    8'h02, 1'b0, 1'b0, 1'b1, 1'b0);
    issue(4'b1101, 8'h81, 8'h00);
    chk_res("shr_81",    8'h40, 1'b0, 1'b0, 1'b1, 1'b0);
    issue(4'b0111, 8'hA5, 8'h11);
    chk_res("pass_0111", 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);

    // Multiply
    issue(4'b1011, 8'h0D, 8'h0B);
    mul_wait("mul_0d_0b");
    chk_res("mul_0d_0b", 8'h8F, 1'b0, 1'b1, 1'b0, 1'b0);
    issue(4'b1011, 8'h14, 8'h14);
    mul_wait("mul_14_14");
    chk_res("mul_14_14", 8'h90, 1'b0, 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("mul.retired", 32'(bus.out_valid), 32'd0);

    // Back-pressure hold, then back-to-back stream
    @(negedge clk);
    bus.out_ready = 1'b0;
    issue(4'b0011, 8'h12, 8'h34);
    chk_res("hold_add", 8'h46, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.ALU_Sel  = 4'b0101;
    bus.A        = 8'h3C;
    bus.B        = 8'h0F;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("hold.ALU_Out",   32'(bus.ALU_Out),   32'h46);
      chk("hold.out_valid", 32'(bus.out_valid), 32'd1);
      chk("hold.in_ready",  32'(bus.in_ready),  32'd0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk_res("stream_and", 8'h0C, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bus.ALU_Sel = 4'b0110;
    @(posedge clk);
    #1;
    chk_res("stream_or", 8'h3F, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bus.ALU_Sel = 4'b0001;
    @(posedge clk);
    #1;
    chk_res("stream_not", 8'hC3, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("stream.drained", 32'(bus.out_valid), 32'd0);

    // Reset during multiply
    issue(4'b1011, 8'h0D, 8'h0B);
    repeat (2) @(posedge clk);
    #1;
    chk("abort.busy", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort.out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort.ALU_Out",   32'(bus.ALU_Out),   32'd0);
    chk("abort.flags",     32'({bus.zero, bus.negative, bus.carry, bus.overflow}), 32'd0);
    chk("abort.in_ready",  32'(bus.in_ready),  32'd1);
    @(negedge clk);
    rst = 1'b0;
    spurious = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) spurious++;
    end
    chk("abort.no_result", 32'(spurious), 32'd0);

    // MUL_EN=0: 1011 passes A
    @(negedge clk);
    bus0.in_valid = 1'b1;
    bus0.ALU_Sel  = 4'b1011;
    bus0.A        = 8'h5A;
    bus0.B        = 8'h03;
    @(posedge clk);
    #1;
    bus0.in_valid = 1'b0;
    chk("nomul.out_valid", 32'(bus0.out_valid), 32'd1);
    chk("nomul.ALU_Out",   32'(bus0.ALU_Out),   32'h5A);
    chk("nomul.flags",     32'({bus0.zero, bus0.negative, bus0.carry, bus0.overflow}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
